hazard_unit: RTL and testbench

//  Pipeline control end of the stage registers: drives the stall/clear inputs of if_id, id_ex, ex_mem, mem_wb.

---
 rtl/hazard_unit_if.sv | 46 ++++
 rtl/hazard_unit.sv | 136 +++++++++++++
 tb/tb_hazard_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic [1:0]       ResultSrcE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             PCSrcE;
    logic             MemReqM;
    logic             MemReadyM;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic             MemErr;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    // Pipeline side: supplies register/hazard info, consumes control
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, MemErr, StallCnt, FlushCnt
    );

    // Hazard unit side
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, MemErr, StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding, stall/flush control, data-memory wait FSM and event counters
module hazard_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    hazard_unit_if.slave hz
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] MEM_ERR  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              mem_busy;
    logic              lw_stall;

    // MEM result beats WB result; x0 is never a forwarding source
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Hazard detection: load-use and memory-busy conditions
    always_comb begin
        lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                   ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        mem_busy = ((state == RUN) && hz.MemReqM && !hz.MemReadyM) ||
                   ((state == MEM_WAIT) && !hz.MemReadyM) ||
                   (state == MEM_ERR);
    end

    // Stage controls; reset forces a clean, flushed pipeline
    always_comb begin
        hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
        hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
        hz.StallF    = mem_busy || (lw_stall && !hz.PCSrcE);
        hz.StallD    = mem_busy || (lw_stall && !hz.PCSrcE);
        hz.StallE    = mem_busy;
        hz.StallM    = mem_busy;
        hz.FlushD    = hz.PCSrcE && !mem_busy;
        hz.FlushE    = (hz.PCSrcE || lw_stall) && !mem_busy;
        hz.FlushW    = mem_busy;
        if (reset) begin
            hz.ForwardAE = 2'b00;
            hz.ForwardBE = 2'b00;
            hz.StallF    = 1'b0;
            hz.StallD    = 1'b0;
            hz.StallE    = 1'b0;
            hz.StallM    = 1'b0;
            hz.FlushD    = 1'b1;
            hz.FlushE    = 1'b1;
            hz.FlushW    = 1'b1;
        end
    end

    // Memory wait FSM next-state: count busy cycles, give up after MEM_TIMEOUT
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            RUN: begin
                if (hz.MemReqM && !hz.MemReadyM) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.MemReadyM) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = MEM_ERR;
                end else begin
                    wait_cnt_next = wait_cnt + WAIT_W'(1);
                end
            end
            MEM_ERR: begin
                state_next = MEM_ERR;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // FSM state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Saturating performance counters for stall and flush cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz.StallF && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (hz.FlushD && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // Registered status outputs
    always_comb begin
        hz.MemErr   = (state == MEM_ERR);
        hz.StallCnt = stall_cnt;
        hz.FlushCnt = flush_cnt;
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit with a behavioural reference model
module tb_hazard_unit;
    localparam int TMO = 4;
    localparam int CW  = 4;

    logic clk;
    logic reset;

    hazard_unit_if #(.CNT_W(CW)) hz ();

    hazard_unit #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          sf, sd, se, sm, fd, fe, fw, err;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model state: sticky error, outstanding miss, unready cycle count
    bit m_err;
    bit m_waiting;
    int m_unready;
    int m_sc;
    int m_fc;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
        if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step();
        exp_t e;
        bit lw, busy;
        lw   = (hz.ResultSrcE == 2'b01) && hz.RdE != 0 &&
               (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
        busy = m_err || (m_waiting ? !hz.MemReadyM : (hz.MemReqM && !hz.MemReadyM));
        if (reset) begin
            e.fa = 0; e.fb = 0;
            e.sf = 0; e.sd = 0; e.se = 0; e.sm = 0;
            e.fd = 1; e.fe = 1; e.fw = 1;
        end else begin
            e.fa = ref_fwd(hz.Rs1E);
            e.fb = ref_fwd(hz.Rs2E);
            e.sf = busy || (lw && !hz.PCSrcE);
            e.sd = e.sf;
            e.se = busy; e.sm = busy; e.fw = busy;
            e.fd = hz.PCSrcE && !busy;
            e.fe = (hz.PCSrcE || lw) && !busy;
        end
        e.err = m_err;
        e.sc  = CW'(m_sc);
        e.fc  = CW'(m_fc);
        e.cyc = cycle;
        q.push_back(e);
        if (reset) begin
            m_err = 0; m_waiting = 0; m_unready = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (e.sf && m_sc < (1 << CW) - 1) m_sc++;
            if (e.fd && m_fc < (1 << CW) - 1) m_fc++;
            if (!m_err) begin
                if (m_waiting) begin
                    if (hz.MemReadyM) begin
                        m_waiting = 0; m_unready = 0;
                    end else begin
                        m_unready++;
                        if (m_unready >= TMO) begin
                            m_err = 1; m_waiting = 0;
                        end
                    end
                end else if (hz.MemReqM && !hz.MemReadyM) begin
                    m_waiting = 1; m_unready = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic clear_inputs();
        hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
        hz.RdE = 0; hz.RdM = 0; hz.RdW = 0; hz.ResultSrcE = 0;
        hz.RegWriteM = 0; hz.RegWriteW = 0; hz.PCSrcE = 0;
        hz.MemReqM = 0; hz.MemReadyM = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int cyc);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ForwardAE", 32'(hz.ForwardAE), 32'(e.fa), e.cyc);
                chk("ForwardBE", 32'(hz.ForwardBE), 32'(e.fb), e.cyc);
                chk("StallF",    32'(hz.StallF),    32'(e.sf), e.cyc);
                chk("StallD",    32'(hz.StallD),    32'(e.sd), e.cyc);
                chk("StallE",    32'(hz.StallE),    32'(e.se), e.cyc);
                chk("StallM",    32'(hz.StallM),    32'(e.sm), e.cyc);
                chk("FlushD",    32'(hz.FlushD),    32'(e.fd), e.cyc);
                chk("FlushE",    32'(hz.FlushE),    32'(e.fe), e.cyc);
                chk("FlushW",    32'(hz.FlushW),    32'(e.fw), e.cyc);
                chk("MemErr",    32'(hz.MemErr),    32'(e.err), e.cyc);
                chk("StallCnt",  32'(hz.StallCnt),  32'(e.sc), e.cyc);
                chk("FlushCnt",  32'(hz.FlushCnt),  32'(e.fc), e.cyc);
            end
        end
    end

    // Stimulus: directed scenarios then randomized traffic
    initial begin
        reset = 1'b1;
        clear_inputs();
        m_err = 0; m_waiting = 0; m_unready = 0; m_sc = 0; m_fc = 0;
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b0;
        step();

        // Forwarding: MEM beats WB, then WB alone, and Rs2E path
        hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1;
        step();
        hz.RegWriteM = 0;
        step();
        hz.Rs2E = 7; hz.RdM = 7; hz.RegWriteM = 1; hz.RdW = 0;
        step();
        hz.Rs1E = 0; hz.Rs2E = 0; hz.RdM = 0; hz.RegWriteW = 1;
        step();
        clear_inputs();

        // Load-use stall, then x0 destination
        hz.ResultSrcE = 2'b01; hz.RdE = 6; hz.Rs2D = 6;
        step();
        hz.ResultSrcE = 2'b00;
        step();
        hz.ResultSrcE = 2'b01; hz.RdE = 0; hz.Rs2D = 0;
        step();

        // Taken branch with load-use
        hz.RdE = 6; hz.Rs1D = 6; hz.PCSrcE = 1;
        step();
        clear_inputs();
        step();

        // Memory wait: three unready cycles then ready
        hz.MemReqM = 1;
        repeat (3) step();
        hz.MemReadyM = 1;
        step();
        clear_inputs();
        step();

        // Timeout into sticky error, ready ignored, then reset recovery
        hz.MemReqM = 1;
        repeat (5) step();
        hz.MemReadyM = 1; hz.PCSrcE = 1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_inputs();
        step();

        // Counter saturation
        hz.ResultSrcE = 2'b01; hz.RdE = 9; hz.Rs1D = 9;
        repeat (20) step();
        hz.PCSrcE = 1;
        repeat (20) step();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Randomized traffic with small register range to force collisions
        for (int i = 0; i < 1500; i++) begin
            reset         = ($urandom_range(0, 59) == 0);
            hz.Rs1D       = 5'($urandom_range(0, 3));
            hz.Rs2D       = 5'($urandom_range(0, 3));
            hz.Rs1E       = 5'($urandom_range(0, 3));
            hz.Rs2E       = 5'($urandom_range(0, 3));
            hz.RdE        = 5'($urandom_range(0, 3));
            hz.RdM        = 5'($urandom_range(0, 3));
            hz.RdW        = 5'($urandom_range(0, 3));
            hz.ResultSrcE = 2'($urandom_range(0, 3));
            hz.RegWriteM  = 1'($urandom_range(0, 1));
            hz.RegWriteW  = 1'($urandom_range(0, 1));
            hz.PCSrcE     = ($urandom_range(0, 3) == 0);
            hz.MemReqM    = ($urandom_range(0, 2) == 0);
            hz.MemReadyM  = ($urandom_range(0, 9) < 6);
            step();
        end
        reset = 1'b0;

        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
